nibble_sequencer: RTL

//  Control unit of the 4-bit processor: two-phase FETCH/EXECUTE sequencer plus C/Z flag register.

---
 rtl/nibble_pkg.sv | 54 +++++
 rtl/nibble_decode.sv | 72 +++++++
 rtl/nibble_sequencer.sv | 78 +++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared constants and control-word layout for the 4-bit processor sequencer.
// Field order in ctl_t defines the packed bit positions of the control word.
package nibble_pkg;

  localparam int ALU_FW = 3;
  localparam int OPC_W  = 4;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  localparam logic [OPC_W-1:0] OP_JC    = 4'h0;
  localparam logic [OPC_W-1:0] OP_JNC   = 4'h1;
  localparam logic [OPC_W-1:0] OP_CMPI  = 4'h2;
  localparam logic [OPC_W-1:0] OP_CMPM  = 4'h3;
  localparam logic [OPC_W-1:0] OP_LIT   = 4'h4;
  localparam logic [OPC_W-1:0] OP_IN    = 4'h5;
  localparam logic [OPC_W-1:0] OP_LD    = 4'h6;
  localparam logic [OPC_W-1:0] OP_ST    = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'h8;
  localparam logic [OPC_W-1:0] OP_JNZ   = 4'h9;
  localparam logic [OPC_W-1:0] OP_ADDI  = 4'hA;
  localparam logic [OPC_W-1:0] OP_ADDM  = 4'hB;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'hC;
  localparam logic [OPC_W-1:0] OP_OUT   = 4'hD;
  localparam logic [OPC_W-1:0] OP_NANDI = 4'hE;
  localparam logic [OPC_W-1:0] OP_NANDM = 4'hF;

  localparam logic [ALU_FW-1:0] ALU_A    = 3'b000;
  localparam logic [ALU_FW-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_FW-1:0] ALU_B    = 3'b010;
  localparam logic [ALU_FW-1:0] ALU_ADD  = 3'b011;
  localparam logic [ALU_FW-1:0] ALU_NAND = 3'b100;

  typedef struct packed {
    logic              inc_pc;
    logic              load_pc;
    logic              en_fetch;
    logic [ALU_FW-1:0] alu_func;
    logic              en_accu;
    logic              en_flags;
    logic              oe_oprnd;
    logic              oe_alu;
    logic              oe_in;
    logic              cs_ram;
    logic              oe_ram;
    logic              we_ram;
    logic              en_out;
  } ctl_t;

  localparam int CTL_W = $bits(ctl_t);

endpackage

// File: rtl/nibble_decode.sv
// Combinational decode of {phase, instruction, registered flags} into the control word.
// Zero latency; unknown opcodes fall to an all-zero word so nothing drives the bus.
module nibble_decode
  import nibble_pkg::*;
(
  input  phase_t           phase,
  input  logic [OPC_W-1:0] instr,
  input  logic [1:0]       flags,
  output ctl_t             ctl
);

  logic w_c;
  logic w_z;

  assign w_c = flags[1];
  assign w_z = flags[0];

  always_comb begin
    ctl = '0;
    if (phase == PH_FETCH) begin
      ctl.en_fetch = 1'b1;
      ctl.inc_pc   = 1'b1;
    end else begin
      case (instr)
        // Untaken conditional jumps still advance PC to skip the address byte.
        OP_JC:  begin ctl.load_pc = w_c;  ctl.inc_pc = !w_c; end
        OP_JNC: begin ctl.load_pc = !w_c; ctl.inc_pc = w_c;  end
        OP_JZ:  begin ctl.load_pc = w_z;  ctl.inc_pc = !w_z; end
        OP_JNZ: begin ctl.load_pc = !w_z; ctl.inc_pc = w_z;  end
        OP_JMP: ctl.load_pc = 1'b1;
        OP_CMPI: begin
          ctl.oe_oprnd = 1'b1; ctl.alu_func = ALU_SUB; ctl.en_flags = 1'b1;
        end
        OP_CMPM: begin
          ctl.cs_ram = 1'b1; ctl.oe_ram = 1'b1; ctl.alu_func = ALU_SUB; ctl.en_flags = 1'b1;
        end
        OP_LIT: begin
          ctl.oe_oprnd = 1'b1; ctl.alu_func = ALU_B; ctl.en_accu = 1'b1; ctl.en_flags = 1'b1;
        end
        OP_IN: begin
          ctl.oe_in = 1'b1; ctl.alu_func = ALU_B; ctl.en_accu = 1'b1; ctl.en_flags = 1'b1;
        end
        OP_LD: begin
          ctl.cs_ram = 1'b1; ctl.oe_ram = 1'b1; ctl.alu_func = ALU_B;
          ctl.en_accu = 1'b1; ctl.en_flags = 1'b1;
        end
        OP_ST: begin
          ctl.cs_ram = 1'b1; ctl.we_ram = 1'b1; ctl.oe_alu = 1'b1; ctl.alu_func = ALU_A;
        end
        OP_ADDI: begin
          ctl.oe_oprnd = 1'b1; ctl.alu_func = ALU_ADD; ctl.en_accu = 1'b1; ctl.en_flags = 1'b1;
        end
        OP_ADDM: begin
          ctl.cs_ram = 1'b1; ctl.oe_ram = 1'b1; ctl.alu_func = ALU_ADD;
          ctl.en_accu = 1'b1; ctl.en_flags = 1'b1;
        end
        OP_OUT: begin
          ctl.oe_alu = 1'b1; ctl.alu_func = ALU_A; ctl.en_out = 1'b1;
        end
        OP_NANDI: begin
          ctl.oe_oprnd = 1'b1; ctl.alu_func = ALU_NAND; ctl.en_accu = 1'b1; ctl.en_flags = 1'b1;
        end
        OP_NANDM: begin
          ctl.cs_ram = 1'b1; ctl.oe_ram = 1'b1; ctl.alu_func = ALU_NAND;
          ctl.en_accu = 1'b1; ctl.en_flags = 1'b1;
        end
        default: ctl = '0;
      endcase
    end
  end

endmodule

// File: rtl/nibble_sequencer.sv
// Two-phase FETCH/EXECUTE sequencer with C/Z flag register; sole source of datapath strobes.
// Strobes are combinational from phase/instr/flags; reset gates every strobe low at once.
module nibble_sequencer
  import nibble_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  instr,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              phase,
  output logic [1:0]        flags,
  output logic              inc_pc,
  output logic              load_pc,
  output logic              en_fetch,
  output logic [ALU_FW-1:0] alu_func,
  output logic              en_accu,
  output logic              en_flags,
  output logic              oe_oprnd,
  output logic              oe_alu,
  output logic              oe_in,
  output logic              cs_ram,
  output logic              oe_ram,
  output logic              we_ram,
  output logic              en_out
);

  phase_t     r_phase;
  phase_t     w_phase_nxt;
  logic [1:0] r_flags;
  ctl_t       w_ctl;
  ctl_t       w_ctl_g;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_phase <= PH_FETCH;
    else       r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = PH_EXEC;
    if (r_phase == PH_EXEC) w_phase_nxt = PH_FETCH;
  end

  nibble_decode u_decode (
    .phase (r_phase),
    .instr (instr),
    .flags (r_flags),
    .ctl   (w_ctl)
  );

  // Gate on the raw reset so strobes drop asynchronously, not at the next edge.
  always_comb begin
    w_ctl_g = w_ctl;
    if (reset) w_ctl_g = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_flags <= 2'b00;
    else if (w_ctl_g.en_flags) r_flags <= {alu_carry, alu_zero};
  end

  assign phase    = (r_phase == PH_EXEC);
  assign flags    = r_flags;
  assign inc_pc   = w_ctl_g.inc_pc;
  assign load_pc  = w_ctl_g.load_pc;
  assign en_fetch = w_ctl_g.en_fetch;
  assign alu_func = w_ctl_g.alu_func;
  assign en_accu  = w_ctl_g.en_accu;
  assign en_flags = w_ctl_g.en_flags;
  assign oe_oprnd = w_ctl_g.oe_oprnd;
  assign oe_alu   = w_ctl_g.oe_alu;
  assign oe_in    = w_ctl_g.oe_in;
  assign cs_ram   = w_ctl_g.cs_ram;
  assign oe_ram   = w_ctl_g.oe_ram;
  assign we_ram   = w_ctl_g.we_ram;
  assign en_out   = w_ctl_g.en_out;

endmodule
